// File: rtl/jpeg_mcu_seq.sv
// MCU block sequencer: tags each decoded 8x8 block with component type and block coordinates.
// Optional restart-interval marking is built when JPEG_MCU_RESTART_EN is defined.
module jpeg_mcu_seq #(
    parameter int unsigned X_W   = 16,
    parameter int unsigned Y_W   = 14,
    parameter int unsigned DIM_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   img_start_i,
    input  logic [DIM_W-1:0]       img_width_i,
    input  logic [DIM_W-1:0]       img_height_i,
    input  logic [2:0]             img_mode_i,
    input  logic [15:0]            restart_interval_i,
    input  logic                   end_of_block_i,
    output logic [2+Y_W+X_W-1:0]   block_id_o,
    output logic [1:0]             block_type_o,
    output logic [2:0]             blk_in_mcu_o,
    output logic                   mcu_first_o,
    output logic                   mcu_last_o,
    output logic                   end_of_image_o,
    output logic                   unsupported_o,
    output logic                   restart_o
);

    localparam int unsigned CW = DIM_W + 1;

    // Latched image geometry and sequencing state
    logic             r_hs, r_vs, r_unsup, r_eoi;
    logic [2:0]       r_nblk, r_ny, r_blk;
    logic [DIM_W-1:0] r_mcu_w, r_mcu_h, r_mx, r_my;

    logic             w_hs, w_vs, w_unsup, w_eoi, w_mcu_done, w_last_mcu;
    logic [2:0]       w_nblk, w_ny, w_blk;
    logic [DIM_W-1:0] w_mcu_w, w_mcu_h, w_mx, w_my;
    logic [CW-1:0]    w_wext, w_hext;

    always_comb begin
        w_hs       = r_hs;
        w_vs       = r_vs;
        w_nblk     = r_nblk;
        w_ny       = r_ny;
        w_unsup    = r_unsup;
        w_mcu_w    = r_mcu_w;
        w_mcu_h    = r_mcu_h;
        w_mx       = r_mx;
        w_my       = r_my;
        w_blk      = r_blk;
        w_eoi      = r_eoi;
        w_mcu_done = 1'b0;
        w_last_mcu = 1'b0;
        w_wext     = '0;
        w_hext     = '0;
        if (img_start_i) begin
            case (img_mode_i)
                3'd1: begin w_hs = 1'b0; w_vs = 1'b0; w_nblk = 3'd3; w_ny = 3'd1; end
                3'd2: begin w_hs = 1'b1; w_vs = 1'b1; w_nblk = 3'd6; w_ny = 3'd4; end
                3'd3: begin w_hs = 1'b1; w_vs = 1'b0; w_nblk = 3'd4; w_ny = 3'd2; end
                default: begin w_hs = 1'b0; w_vs = 1'b0; w_nblk = 3'd1; w_ny = 3'd1; end
            endcase
            w_unsup = img_mode_i[2];
            // Extra bit keeps the round-up add from overflowing at full-scale width
            w_wext  = CW'(img_width_i) + (w_hs ? CW'(15) : CW'(7));
            w_hext  = CW'(img_height_i) + (w_vs ? CW'(15) : CW'(7));
            w_mcu_w = DIM_W'(w_hs ? (w_wext >> 4) : (w_wext >> 3));
            w_mcu_h = DIM_W'(w_vs ? (w_hext >> 4) : (w_hext >> 3));
            w_mx    = '0;
            w_my    = '0;
            w_blk   = '0;
            w_eoi   = (img_width_i == '0) || (img_height_i == '0);
        end else if (end_of_block_i && !r_eoi) begin
            if (r_blk == r_nblk - 3'd1) begin
                w_blk      = '0;
                w_mcu_done = 1'b1;
                if (r_mx == r_mcu_w - DIM_W'(1)) begin
                    if (r_my == r_mcu_h - DIM_W'(1)) begin
                        w_eoi      = 1'b1;
                        w_last_mcu = 1'b1;
                    end else begin
                        w_mx = '0;
                        w_my = r_my + DIM_W'(1);
                    end
                end else begin
                    w_mx = r_mx + DIM_W'(1);
                end
            end else begin
                w_blk = r_blk + 3'd1;
            end
        end
    end

    // Descriptor for the block that becomes current after this edge
    logic          w_is_y;
    logic [1:0]    w_type;
    logic [CW-1:0] w_xc, w_yc;

    always_comb begin
        w_is_y = (w_blk < w_ny);
        w_type = 2'd0;
        if (w_eoi)                w_type = 2'd3;
        else if (w_is_y)          w_type = 2'd0;
        else if (w_blk == w_ny)   w_type = 2'd1;
        else                      w_type = 2'd2;
        w_xc = CW'(w_mx);
        w_yc = CW'(w_my);
        if (w_is_y && w_hs) w_xc = {w_mx, 1'b0} | CW'(w_blk[0]);
        if (w_is_y && w_vs) w_yc = {w_my, 1'b0} | CW'(w_blk[1]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hs           <= 1'b0;
            r_vs           <= 1'b0;
            r_unsup        <= 1'b0;
            r_eoi          <= 1'b0;
            r_nblk         <= 3'd1;
            r_ny           <= 3'd1;
            r_blk          <= '0;
            r_mcu_w        <= '0;
            r_mcu_h        <= '0;
            r_mx           <= '0;
            r_my           <= '0;
            block_id_o     <= '0;
            block_type_o   <= '0;
            blk_in_mcu_o   <= '0;
            mcu_first_o    <= 1'b1;
            mcu_last_o     <= 1'b1;
            end_of_image_o <= 1'b0;
            unsupported_o  <= 1'b0;
        end else begin
            r_hs           <= w_hs;
            r_vs           <= w_vs;
            r_unsup        <= w_unsup;
            r_eoi          <= w_eoi;
            r_nblk         <= w_nblk;
            r_ny           <= w_ny;
            r_blk          <= w_blk;
            r_mcu_w        <= w_mcu_w;
            r_mcu_h        <= w_mcu_h;
            r_mx           <= w_mx;
            r_my           <= w_my;
            block_id_o     <= {w_type, Y_W'(w_yc), X_W'(w_xc)};
            block_type_o   <= w_type;
            blk_in_mcu_o   <= w_blk;
            mcu_first_o    <= (w_blk == 3'd0);
            mcu_last_o     <= (w_blk == w_nblk - 3'd1);
            end_of_image_o <= w_eoi;
            unsupported_o  <= w_unsup;
        end
    end

`ifdef JPEG_MCU_RESTART_EN
    // Completed-MCU counter; the final MCU of an image never pulses
    logic [15:0] r_rint, r_rcnt, w_rint, w_rcnt;
    logic        w_restart;

    always_comb begin
        w_rint    = r_rint;
        w_rcnt    = r_rcnt;
        w_restart = 1'b0;
        if (img_start_i) begin
            w_rint = restart_interval_i;
            w_rcnt = '0;
        end else if (w_mcu_done && !w_last_mcu) begin
            if ((r_rint != 16'd0) && (r_rcnt + 16'd1 == r_rint)) begin
                w_restart = 1'b1;
                w_rcnt    = '0;
            end else begin
                w_rcnt = r_rcnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rint    <= '0;
            r_rcnt    <= '0;
            restart_o <= 1'b0;
        end else begin
            r_rint    <= w_rint;
            r_rcnt    <= w_rcnt;
            restart_o <= w_restart;
        end
    end
`else
    logic w_unused_restart;
    assign w_unused_restart = ^{restart_interval_i, w_last_mcu, w_mcu_done};
    assign restart_o = 1'b0;
`endif

endmodule

// File: tb/tb_jpeg_mcu_seq.sv
// Self-checking bench for jpeg_mcu_seq: per-cycle vector table fed through an expected-value queue.
module tb_jpeg_mcu_seq;

`ifdef JPEG_MCU_RESTART_EN
    localparam bit RST_EN = 1'b1;
`else
    localparam bit RST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        img_start_i = 1'b0;
    logic [15:0] img_width_i = '0;
    logic [15:0] img_height_i = '0;
    logic [2:0]  img_mode_i = '0;
    logic [15:0] restart_interval_i = '0;
    logic        end_of_block_i = 1'b0;
    logic [31:0] block_id_o;
    logic [1:0]  block_type_o;
    logic [2:0]  blk_in_mcu_o;
    logic        mcu_first_o, mcu_last_o, end_of_image_o, unsupported_o, restart_o;

    jpeg_mcu_seq dut (
        .clk_i(clk), .rst_ni(rst_ni), .img_start_i(img_start_i),
        .img_width_i(img_width_i), .img_height_i(img_height_i), .img_mode_i(img_mode_i),
        .restart_interval_i(restart_interval_i), .end_of_block_i(end_of_block_i),
        .block_id_o(block_id_o), .block_type_o(block_type_o), .blk_in_mcu_o(blk_in_mcu_o),
        .mcu_first_o(mcu_first_o), .mcu_last_o(mcu_last_o), .end_of_image_o(end_of_image_o),
        .unsupported_o(unsupported_o), .restart_o(restart_o)
    );

    always #5 clk = ~clk;

    // One row per clock: inputs for that cycle, then the outputs expected after the edge.
    // dc = only type/eoi/unsupported/restart are defined (end-of-image hold).
    typedef struct {
        bit          rs, st;
        logic [2:0]  md;
        logic [15:0] w, h, ri;
        bit          eob, dc;
        logic [1:0]  t;
        logic [15:0] x;
        logic [13:0] y;
        logic [2:0]  b;
        bit          f, l, e, u, r;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void add(bit rs, bit st, logic [2:0] md, logic [15:0] w, logic [15:0] h,
                                logic [15:0] ri, bit eob, bit dc, logic [1:0] t, logic [15:0] x,
                                logic [13:0] y, logic [2:0] b, bit f, bit l, bit e, bit u, bit r);
        vec_t v;
        v.rs = rs; v.st = st; v.md = md; v.w = w; v.h = h; v.ri = ri; v.eob = eob; v.dc = dc;
        v.t = t; v.x = x; v.y = y; v.b = b; v.f = f; v.l = l; v.e = e; v.u = u; v.r = r;
        vecs.push_back(v);
    endfunction

    function automatic void s(logic [2:0] md, logic [15:0] w, logic [15:0] h, logic [15:0] ri,
                              bit f, bit l, bit u);
        add(0, 1, md, w, h, ri, 0, 0, 2'd0, 16'd0, 14'd0, 3'd0, f, l, 0, u, 0);
    endfunction

    function automatic void k(logic [1:0] t, logic [15:0] x, logic [13:0] y, logic [2:0] b,
                              bit f, bit l, bit u, bit r);
        add(0, 0, 0, 0, 0, 0, 1, 0, t, x, y, b, f, l, 0, u, r);
    endfunction

    function automatic void eoi(bit u);
        add(0, 0, 0, 0, 0, 0, 1, 1, 2'd3, 16'd0, 14'd0, 3'd0, 0, 0, 1, u, 0);
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    initial begin
        // reset state
        add(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 16'd0, 14'd0, 3'd0, 1, 1, 0, 0, 0);
        // mono 16x8, with an idle cycle and an ignored strobe after end of image
        s(3'd0, 16, 8, 0, 1, 1, 0);
        k(0, 1, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 16'd1, 14'd0, 3'd0, 1, 1, 0, 0, 0);
        eoi(0);
        eoi(0);
        // 444 8x8
        s(3'd1, 8, 8, 0, 1, 0, 0);
        k(1, 0, 0, 1, 0, 0, 0, 0);
        k(2, 0, 0, 2, 0, 1, 0, 0);
        eoi(0);
        // 420 32x16
        s(3'd2, 32, 16, 0, 1, 0, 0);
        k(0, 1, 0, 1, 0, 0, 0, 0); k(0, 0, 1, 2, 0, 0, 0, 0); k(0, 1, 1, 3, 0, 0, 0, 0);
        k(1, 0, 0, 4, 0, 0, 0, 0); k(2, 0, 0, 5, 0, 1, 0, 0);
        k(0, 2, 0, 0, 1, 0, 0, 0); k(0, 3, 0, 1, 0, 0, 0, 0); k(0, 2, 1, 2, 0, 0, 0, 0);
        k(0, 3, 1, 3, 0, 0, 0, 0); k(1, 1, 0, 4, 0, 0, 0, 0); k(2, 1, 0, 5, 0, 1, 0, 0);
        eoi(0);
        // 422 17x8 (two MCUs wide)
        s(3'd3, 17, 8, 0, 1, 0, 0);
        k(0, 1, 0, 1, 0, 0, 0, 0); k(1, 0, 0, 2, 0, 0, 0, 0); k(2, 0, 0, 3, 0, 1, 0, 0);
        k(0, 2, 0, 0, 1, 0, 0, 0); k(0, 3, 0, 1, 0, 0, 0, 0); k(1, 1, 0, 2, 0, 0, 0, 0);
        k(2, 1, 0, 3, 0, 1, 0, 0);
        eoi(0);
        // 444 32x8 restarted mid-image with a coincident strobe (strobe dropped)
        s(3'd1, 32, 8, 0, 1, 0, 0);
        k(1, 0, 0, 1, 0, 0, 0, 0); k(2, 0, 0, 2, 0, 1, 0, 0);
        k(0, 1, 0, 0, 1, 0, 0, 0); k(1, 1, 0, 1, 0, 0, 0, 0);
        add(0, 1, 3'd1, 32, 8, 0, 1, 0, 2'd0, 16'd0, 14'd0, 3'd0, 1, 0, 0, 0, 0);
        k(1, 0, 0, 1, 0, 0, 0, 0);
        // unsupported mode runs as mono, then reset mid-image with a strobe
        s(3'd5, 16, 8, 0, 1, 1, 1);
        k(0, 1, 0, 0, 1, 1, 1, 0);
        add(1, 0, 0, 0, 0, 0, 1, 0, 2'd0, 16'd0, 14'd0, 3'd0, 1, 1, 0, 0, 0);
        s(3'd1, 8, 8, 0, 1, 0, 0);
        // zero width / zero height
        add(0, 1, 3'd0, 0, 8, 0, 0, 1, 2'd3, 16'd0, 14'd0, 3'd0, 0, 0, 1, 0, 0);
        add(0, 1, 3'd2, 16, 0, 0, 0, 1, 2'd3, 16'd0, 14'd0, 3'd0, 0, 0, 1, 0, 0);
        eoi(0);
        // restart interval 2, mono 32x8: single pulse after block 2 only
        s(3'd0, 32, 8, 2, 1, 1, 0);
        k(0, 1, 0, 0, 1, 1, 0, 0); k(0, 2, 0, 0, 1, 1, 0, RST_EN);
        k(0, 3, 0, 0, 1, 1, 0, 0);
        eoi(0);
        // restart interval 0: never pulses
        s(3'd0, 32, 8, 0, 1, 1, 0);
        k(0, 1, 0, 0, 1, 1, 0, 0); k(0, 2, 0, 0, 1, 1, 0, 0); k(0, 3, 0, 0, 1, 1, 0, 0);
        eoi(0);
        // full-scale width must not collapse the MCU grid
        s(3'd3, 16'hFFFF, 8, 0, 1, 0, 0);
        k(0, 1, 0, 1, 0, 0, 0, 0); k(1, 0, 0, 2, 0, 0, 0, 0); k(2, 0, 0, 3, 0, 1, 0, 0);
        k(0, 2, 0, 0, 1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v, x;
            v = vecs[i];
            rst_ni             = !v.rs;
            img_start_i        = v.st;
            img_mode_i         = v.md;
            img_width_i        = v.w;
            img_height_i       = v.h;
            restart_interval_i = v.ri;
            end_of_block_i     = v.eob;
            sb.push_back(v);
            @(posedge clk);
            #1;
            x = sb.pop_front();
            chk("block_type", i, 32'(block_type_o), 32'(x.t));
            chk("end_of_image", i, 32'(end_of_image_o), 32'(x.e));
            chk("unsupported", i, 32'(unsupported_o), 32'(x.u));
            chk("restart", i, 32'(restart_o), 32'(x.r));
            if (!x.dc) begin
                chk("block_id", i, block_id_o, {x.t, x.y, x.x});
                chk("blk_in_mcu", i, 32'(blk_in_mcu_o), 32'(x.b));
                chk("mcu_first", i, 32'(mcu_first_o), 32'(x.f));
                chk("mcu_last", i, 32'(mcu_last_o), 32'(x.l));
            end
            rst_ni = 1'b1;
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
